// File: rtl/addr_data_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : addr_data_queue_if                                           |
// | Description : Handshake/status bundle for addr_data_queue.                 |
// |               master = producer/consumer side, slave = the queue itself.   |
// |   in_valid/in_ready/in_addr/in_data : push side                            |
// |   out_valid/out_ready/out_addr/out_data : pop side (front of queue)        |
// |   flush : synchronous clear; count/empty/full : occupancy status          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface addr_data_queue_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  modport master (
    output in_valid, in_addr, in_data, out_ready, flush,
    input  in_ready, out_valid, out_addr, out_data, count, empty, full
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready, flush,
    output in_ready, out_valid, out_addr, out_data, count, empty, full
  );
endinterface
`default_nettype wire

// File: rtl/addr_data_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : addr_data_queue                                              |
// | Description : Register-based address/data queue, FIFO or LIFO order,       |
// |               first-word-fall-through front, valid/ready on both sides.    |
// |   clk  : clock, all state on rising edge                                   |
// |   rst  : asynchronous active-high reset (count and pointers only)          |
// |   bus  : addr_data_queue_if.slave (push, pop, flush, count/empty/full)     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module addr_data_queue #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int LIFO  = 0
) (
  input wire logic          clk,
  input wire logic          rst,
  addr_data_queue_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  // Status is decoded from the count register only, so in_ready never
  // depends on out_ready and there is no input-to-output path.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  generate
    if (LIFO != 0) begin : g_lifo
      logic [PW-1:0] w_top;
      // At count == DEPTH the low bits wrap to 0, so top lands on DEPTH-1.
      assign w_top    = r_count[PW-1:0] - PW'(1);
      assign w_rd_idx = w_top;
      // Simultaneous push/pop replaces the entry being handed out.
      assign w_wr_idx = w_pop ? w_top : r_count[PW-1:0];
    end else begin : g_fifo
      logic [PW-1:0] r_wp;
      logic [PW-1:0] r_rp;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wp <= '0;
          r_rp <= '0;
        end else if (bus.flush) begin
          r_wp <= '0;
          r_rp <= '0;
        end else begin
          if (w_push) r_wp <= r_wp + PW'(1);
          if (w_pop)  r_rp <= r_rp + PW'(1);
        end
      end
      assign w_wr_idx = r_wp;
      assign w_rd_idx = r_rp;
    end
  endgenerate

  // Storage is deliberately not reset; only occupancy defines validity.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) begin
      r_mem[w_wr_idx] <= {bus.in_addr, bus.in_data};
    end
  end

  assign {bus.out_addr, bus.out_data} = r_mem[w_rd_idx];
endmodule
`default_nettype wire

// File: tb/tb_addr_data_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_addr_data_queue                                           |
// | Description : Self-checking bench for addr_data_queue, one FIFO and one    |
// |               LIFO instance, vector table plus directed corner sequences.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_addr_data_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addr_data_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) fif ();
  addr_data_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) lif ();

  addr_data_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LIFO(0)) u_fifo (
    .clk(clk), .rst(rst), .bus(fif.slave));
  addr_data_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LIFO(1)) u_lifo (
    .clk(clk), .rst(rst), .bus(lif.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lifo;
    logic        iv;
    logic [31:0] ia;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic [4:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic        chk_front;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic iv, input logic [31:0] ia,
                       input logic [31:0] id, input logic ordy, input logic fl);
    if (sel) begin
      lif.in_valid = iv; lif.in_addr = ia; lif.in_data = id;
      lif.out_ready = ordy; lif.flush = fl;
      fif.in_valid = 1'b0; fif.out_ready = 1'b0; fif.flush = 1'b0;
    end else begin
      fif.in_valid = iv; fif.in_addr = ia; fif.in_data = id;
      fif.out_ready = ordy; fif.flush = fl;
      lif.in_valid = 1'b0; lif.out_ready = 1'b0; lif.flush = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic lifo, input logic iv, input int ia, input int id,
                              input logic ordy, input logic fl, input int e_cnt,
                              input logic e_ov, input logic e_ir, input logic chk_front,
                              input int e_addr, input int e_data);
    vec_t v;
    v.lifo = lifo; v.iv = iv; v.ia = ia; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_cnt = 5'(e_cnt); v.e_ov = e_ov; v.e_ir = e_ir; v.chk_front = chk_front;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  // Outputs depend only on registers, so the pre-edge state is checked right
  // after the inputs for this cycle are applied.
  task automatic apply(input vec_t v, input int idx);
    logic [4:0]  c;
    logic        ov, ir, em, fu;
    logic [31:0] oa, od;
    drive(v.lifo, v.iv, v.ia, v.id, v.ordy, v.fl);
    if (v.lifo) begin
      c = lif.count; ov = lif.out_valid; ir = lif.in_ready; em = lif.empty;
      fu = lif.full; oa = lif.out_addr; od = lif.out_data;
    end else begin
      c = fif.count; ov = fif.out_valid; ir = fif.in_ready; em = fif.empty;
      fu = fif.full; oa = fif.out_addr; od = fif.out_data;
    end
    chk($sformatf("v%0d count", idx), 64'(c), 64'(v.e_cnt));
    chk($sformatf("v%0d out_valid", idx), 64'(ov), 64'(v.e_ov));
    chk($sformatf("v%0d in_ready", idx), 64'(ir), 64'(v.e_ir));
    chk($sformatf("v%0d empty", idx), 64'(em), 64'(v.e_cnt == 5'd0));
    chk($sformatf("v%0d full", idx), 64'(fu), 64'(v.e_cnt == 5'd16));
    if (v.chk_front) begin
      chk($sformatf("v%0d out_addr", idx), 64'(oa), 64'(v.e_addr));
      chk($sformatf("v%0d out_data", idx), 64'(od), 64'(v.e_data));
    end
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [63:0] q[$];

  initial begin
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // ---------------- vector table ----------------
    // idle after reset with out_ready high
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    // FIFO: 10 pushes addr 1..10, data 2..20
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(0, 1, i, 2 * i, 0, 0, i - 1, i > 1, 1, i > 1, 1, 2));
    // FIFO drain in order
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 11 - k, 1, 1, 1, k, 2 * k));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // LIFO: push 3, pop newest first
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4, 0, 0, 1, 1, 1, 1, 1, 2));
    tbl.push_back(mk(1, 1, 5, 6, 0, 0, 2, 1, 1, 1, 3, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 3, 1, 1, 1, 5, 6));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 1, 1, 1, 3, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 2));
    // LIFO: simultaneous push (7,8) and pop at count=2
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4, 0, 0, 1, 1, 1, 1, 1, 2));
    tbl.push_back(mk(1, 1, 7, 8, 1, 0, 2, 1, 1, 1, 3, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, 1, 1, 1, 7, 8));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 1, 1, 1, 7, 8));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    // reset released between edges
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // ---------------- full / wrap (FIFO) ----------------
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(1000 + i), 32'(2000 + i), 1'b0, 1'b0);
      tick();
      q.push_back({32'(1000 + i), 32'(2000 + i)});
    end
    chk("full count", 64'(fif.count), 64'd16);
    chk("full flag", 64'(fif.full), 64'd1);
    chk("full in_ready", 64'(fif.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h55, 32'h55, 1'b0, 1'b0);
      tick();
      chk("full hold count", 64'(fif.count), 64'd16);
    end
    begin
      int n = 16;
      for (int j = 0; j < 40; j++) begin
        int   cnt;
        logic ordy, push_ok, pop_ok;
        cnt  = q.size();
        ordy = (j % 4) != 3;
        drive(1'b0, 1'b1, 32'(1000 + n), 32'(2000 + n), ordy, 1'b0);
        chk("wrap in_ready", 64'(fif.in_ready), 64'(cnt < 16));
        chk("wrap count", 64'(fif.count), 64'(cnt));
        if (cnt > 0) chk("wrap front", {fif.out_addr, fif.out_data}, q[0]);
        push_ok = cnt < 16;
        pop_ok  = ordy && cnt > 0;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) begin
          q.push_back({32'(1000 + n), 32'(2000 + n)});
          n++;
        end
        tick();
      end
    end
    for (int g = 0; g < 20 && q.size() > 0; g++) begin
      drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      chk("drain front", {fif.out_addr, fif.out_data}, q[0]);
      void'(q.pop_front());
      tick();
    end
    chk("drain empty", 64'(fif.empty), 64'd1);

    // ---------------- flush ----------------
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 32'(500 + i), 32'(600 + i), 1'b0, 1'b0);
      tick();
    end
    chk("preflush count", 64'(fif.count), 64'd7);
    drive(1'b0, 1'b1, 32'hAA, 32'hBB, 1'b1, 1'b1);
    tick();
    chk("flush count", 64'(fif.count), 64'd0);
    chk("flush empty", 64'(fif.empty), 64'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      tick();
      chk("postflush out_valid", 64'(fif.out_valid), 64'd0);
    end
    drive(1'b0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
    tick();
    chk("postflush front", {fif.out_addr, fif.out_data}, {32'h11, 32'h22});
    chk("postflush count", 64'(fif.count), 64'd1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    chk("postflush drained", 64'(fif.empty), 64'd1);

    // ---------------- async reset mid-burst ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'(700 + i), 32'(800 + i), 1'b0, 1'b0);
      tick();
    end
    chk("prerst count", 64'(fif.count), 64'd5);
    drive(1'b0, 1'b1, 32'h99, 32'h99, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async count", 64'(fif.count), 64'd0);
    chk("async out_valid", 64'(fif.out_valid), 64'd0);
    chk("async in_ready", 64'(fif.in_ready), 64'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b0, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0);
    tick();
    chk("rst push valid", 64'(fif.out_valid), 64'd1);
    chk("rst push front", {fif.out_addr, fif.out_data}, {32'h77, 32'h88});
    chk("rst push count", 64'(fif.count), 64'd1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    chk("final empty", 64'(fif.empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
